// File: rtl/rac_array_if.sv
// Request/response bus of the redundancy address comparator array.
// The master issues fault requests; the slave returns one response strobe per accepted request.
interface rac_array_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BLK_W   = 2,
  parameter int unsigned ENTRIES = 8
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [BLK_W-1:0]  req_block;
  logic              req_alloc;
  logic              req_rlss;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;
  logic              rsp_new;
  logic              rsp_ovf;
  logic [CNT_W-1:0]  used_cnt;
  logic              full;

  modport master (
    output req_valid, req_addr, req_block, req_alloc, req_rlss,
    input  req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_new, rsp_ovf, used_cnt, full
  );

  modport slave (
    input  req_valid, req_addr, req_block, req_alloc, req_rlss,
    output req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_new, rsp_ovf, used_cnt, full
  );
endinterface

// File: rtl/rac_array.sv
// Multi-entry spare-row address comparator: two-stage compare of each fault address
// against all allocated spares, with lowest-free allocation and same-edge bypass.
module rac_array #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BLK_W   = 2,
  parameter int unsigned ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  rac_array_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] ent_v;
  logic [ADDR_W-1:0]  ent_addr [ENTRIES];
  logic [BLK_W-1:0]   ent_blk  [ENTRIES];
  logic [ENTRIES-1:0] ent_rlss;

  logic               ready_q;
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [BLK_W-1:0]   s1_blk;
  logic               s1_alloc;
  logic               s1_rlss;
  logic [ENTRIES-1:0] s1_match;

  logic               rsp_valid_q, rsp_hit_q, rsp_new_q, rsp_ovf_q, full_q;
  logic [IDX_W-1:0]   rsp_idx_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [ENTRIES-1:0] tbl_match;
  logic [ENTRIES-1:0] byp_vec;
  logic               accept, s1_hit, do_alloc, do_ovf, byp;
  logic [IDX_W-1:0]   hit_idx, free_idx, out_idx;
  logic [CNT_W-1:0]   cnt_nxt;

  function automatic logic [IDX_W-1:0] lowest(input logic [ENTRIES-1:0] vec);
    logic found;
    lowest = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (vec[i] && !found) begin
        lowest = IDX_W'(i);
        found  = 1'b1;
      end
    end
  endfunction

  assign bus.req_ready = ready_q & ~clr;
  assign accept        = bus.req_valid & bus.req_ready;

  // Stage 2 decision; the incoming request also compares against the entry being written now.
  always_comb begin
    tbl_match = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      tbl_match[i] = ent_v[i] && (ent_addr[i] == bus.req_addr) &&
                     (ent_rlss[i] || (ent_blk[i] == bus.req_block));
    end
    s1_hit   = s1_valid & (|s1_match);
    hit_idx  = lowest(s1_match);
    free_idx = lowest(~ent_v);
    do_alloc = s1_valid & s1_alloc & ~s1_hit & ~full_q;
    do_ovf   = s1_valid & s1_alloc & ~s1_hit & full_q;
    byp      = do_alloc && (bus.req_addr == s1_addr) && (s1_rlss || (bus.req_block == s1_blk));
    byp_vec  = byp ? (ENTRIES'(1) << free_idx) : '0;
    out_idx  = s1_hit ? hit_idx : (do_alloc ? free_idx : '0);
    cnt_nxt  = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v       <= '0;
      ent_rlss    <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ent_addr[i] <= '0;
        ent_blk[i]  <= '0;
      end
      ready_q     <= 1'b0;
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s1_blk      <= '0;
      s1_alloc    <= 1'b0;
      s1_rlss     <= 1'b0;
      s1_match    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_new_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_idx_q   <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (clr) begin
        ent_v       <= '0;
        s1_valid    <= 1'b0;
        rsp_valid_q <= 1'b0;
        rsp_hit_q   <= 1'b0;
        rsp_new_q   <= 1'b0;
        rsp_ovf_q   <= 1'b0;
        rsp_idx_q   <= '0;
        cnt_q       <= '0;
        full_q      <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          s1_addr  <= bus.req_addr;
          s1_blk   <= bus.req_block;
          s1_alloc <= bus.req_alloc;
          s1_rlss  <= bus.req_rlss;
          s1_match <= tbl_match | byp_vec;
        end
        rsp_valid_q <= s1_valid;
        rsp_hit_q   <= s1_hit;
        rsp_new_q   <= do_alloc;
        rsp_ovf_q   <= do_ovf;
        rsp_idx_q   <= out_idx;
        if (do_alloc) begin
          ent_v[free_idx]    <= 1'b1;
          ent_addr[free_idx] <= s1_addr;
          ent_blk[free_idx]  <= s1_blk;
          ent_rlss[free_idx] <= s1_rlss;
          cnt_q              <= cnt_nxt;
          full_q             <= (cnt_nxt == CNT_W'(ENTRIES));
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_new   = rsp_new_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign bus.used_cnt  = cnt_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_rac_array.sv
// Scoreboard bench for rac_array: a sequential list model predicts each response at issue
// time; a negedge monitor pops and compares whenever the DUT strobes rsp_valid.
module tb_rac_array;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned BLK_W   = 2;
  localparam int unsigned ENTRIES = 4;

  typedef struct {
    bit hit;
    bit nw;
    bit ovf;
    int idx;
    int cnt;
    bit full;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q[$];
  exp_t mon_e;

  logic [ADDR_W-1:0] m_addr [ENTRIES];
  logic [BLK_W-1:0]  m_blk  [ENTRIES];
  bit                m_rlss [ENTRIES];
  int                m_cnt = 0;

  rac_array_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .ENTRIES(ENTRIES)) bus ();

  rac_array #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Spare list model: entries fill from index 0 upward and are only emptied by clear/reset.
  task automatic model_req(input logic [ADDR_W-1:0] a, input logic [BLK_W-1:0] b,
                           input bit alloc, input bit rlss, output exp_t e);
    int hit_at;
    hit_at = -1;
    e = '{hit: 0, nw: 0, ovf: 0, idx: 0, cnt: 0, full: 0, cyc: 0};
    for (int i = 0; i < m_cnt; i++)
      if (hit_at < 0 && m_addr[i] == a && (m_rlss[i] || m_blk[i] == b)) hit_at = i;
    if (hit_at >= 0) begin
      e.hit = 1; e.idx = hit_at;
    end else if (alloc) begin
      if (m_cnt < int'(ENTRIES)) begin
        m_addr[m_cnt] = a; m_blk[m_cnt] = b; m_rlss[m_cnt] = rlss;
        e.nw = 1; e.idx = m_cnt;
        m_cnt++;
      end else begin
        e.ovf = 1;
      end
    end
    e.cnt  = m_cnt;
    e.full = (m_cnt == int'(ENTRIES));
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [BLK_W-1:0] b,
                       input bit alloc, input bit rlss);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_block = b;
    bus.req_alloc = alloc;
    bus.req_rlss  = rlss;
    model_req(a, b, alloc, rlss, e);
    e.cyc = cyc + 2;
    q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drop_from(input int c);
    while (q.size() > 0 && q[$].cyc >= c) void'(q.pop_back());
  endtask

  task automatic clear();
    bus.req_valid = 1'b0;
    clr = 1'b1;
    #1 chk("req_ready_during_clr", int'(bus.req_ready), 0);
    drop_from(cyc + 1);
    @(negedge clk);
    clr = 1'b0;
    m_cnt = 0;
    chk("used_cnt_after_clr", int'(bus.used_cnt), 0);
    chk("full_after_clr", int'(bus.full), 0);
  endtask

  function automatic int out_word();
    return int'({bus.rsp_valid, bus.rsp_hit, bus.rsp_new, bus.rsp_ovf,
                 bus.rsp_idx, bus.used_cnt, bus.full, bus.req_ready});
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr(input int k);
    case (k)
      0: return 10'h155;
      1: return 10'h0A0;
      2: return 10'h0A1;
      3: return 10'h3FF;
      4: return 10'h000;
      5: return 10'h2AA;
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding prediction on its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d with nothing outstanding", cyc);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != cyc || bus.rsp_hit !== mon_e.hit || bus.rsp_new !== mon_e.nw ||
              bus.rsp_ovf !== mon_e.ovf || int'(bus.rsp_idx) != mon_e.idx ||
              int'(bus.used_cnt) != mon_e.cnt || bus.full !== mon_e.full) begin
            errors++;
            $display("FAIL rsp: cyc=%0d hit=%0b new=%0b ovf=%0b idx=%0d cnt=%0d full=%0b expected cyc=%0d hit=%0b new=%0b ovf=%0b idx=%0d cnt=%0d full=%0b",
                     cyc, bus.rsp_hit, bus.rsp_new, bus.rsp_ovf, bus.rsp_idx, bus.used_cnt, bus.full,
                     mon_e.cyc, mon_e.hit, mon_e.nw, mon_e.ovf, mon_e.idx, mon_e.cnt, mon_e.full);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp: no rsp_valid at cycle %0d, expected by cycle %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int wait_cyc;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_block = '0;
    bus.req_alloc = 1'b0;
    bus.req_rlss  = 1'b0;
    repeat (2) @(negedge clk);
    chk("outputs_in_reset", out_word(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("req_ready_after_reset", int'(bus.req_ready), 1);
    chk("used_cnt_after_reset", int'(bus.used_cnt), 0);

    // Allocate then hit the same spare.
    issue(10'h155, 2'd1, 1, 0);
    idle(3);
    issue(10'h155, 2'd1, 1, 0);
    idle(3);

    // Block qualification and RLSS wildcard.
    clear();
    issue(10'h0A0, 2'd2, 1, 0);
    issue(10'h0A0, 2'd3, 0, 0);
    issue(10'h0A1, 2'd2, 1, 1);
    idle(2);
    issue(10'h0A1, 2'd0, 0, 0);
    idle(3);

    // Back-to-back identical allocations exercise the bypass path.
    clear();
    issue(10'h3FF, 2'd0, 1, 0);
    issue(10'h3FF, 2'd0, 1, 0);
    idle(3);
    chk("used_cnt_bypass", int'(bus.used_cnt), 1);

    // Fill the table and overflow.
    clear();
    for (int i = 0; i < 5; i++) issue(ADDR_W'(16 * i + 3), 2'd1, 1, 0);
    issue(10'h023, 2'd1, 0, 0);
    idle(3);
    chk("full_when_filled", int'(bus.full), 1);
    chk("used_cnt_when_filled", int'(bus.used_cnt), 4);

    // Clear kills the in-flight allocation.
    clear();
    issue(10'h1C3, 2'd2, 1, 0);
    clear();
    idle(2);
    issue(10'h1C3, 2'd2, 0, 0);
    idle(3);

    // Randomised traffic over a small address pool so hits, bypasses and overflows recur.
    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 39) begin
        idle(3);
        clear();
      end
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(pick_addr(int'($urandom_range(0, 6))), BLK_W'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    idle(3);

    // Reset pulse with two requests in flight.
    issue(10'h2AA, 2'd0, 1, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h2AB;
    bus.req_block = 2'd1;
    bus.req_alloc = 1'b1;
    bus.req_rlss  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.req_valid = 1'b0;
    drop_from(cyc);
    @(negedge clk);
    chk("outputs_in_midrun_reset", out_word(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("req_ready_after_midrun_reset", int'(bus.req_ready), 1);
    chk("used_cnt_after_midrun_reset", int'(bus.used_cnt), 0);
    issue(10'h2AA, 2'd0, 0, 0);
    idle(1);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
